// File: rtl/mask_pkg.sv
// Shared types and helpers for the mask decoder.
package mask_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_e;

    localparam int SEQ_WIDTH_DEF    = 20;
    localparam int OFFSET_WIDTH_DEF = 7;

    // Width of a bit index into a vector of w bits (at least one bit).
    function automatic int idx_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/mask_decode_lsb_find.sv
// Lowest-set-bit finder: index of the lowest set bit, any-set flag, at-most-one-set flag.
module lsb_find
    import mask_pkg::*;
#(
    parameter int WIDTH = SEQ_WIDTH_DEF
) (
    input  logic [WIDTH-1:0]            vec,
    output logic [idx_width(WIDTH)-1:0] idx,
    output logic                        any,
    output logic                        single
);

    localparam int IW = idx_width(WIDTH);

    logic found;

    // Priority scan from bit 0 upward; idx stays 0 when vec is empty.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (vec[i] && !found) begin
                idx   = IW'(i);
                found = 1'b1;
            end
        end
    end

    assign any    = |vec;
    // Clearing the lowest set bit leaves zero exactly when popcount <= 1.
    assign single = ((vec & (vec - WIDTH'(1))) == '0);

endmodule

// File: rtl/mask_decode.sv
// Mask decoder: turns a position mask into one absolute offset per set bit,
// lowest bit first. An empty mask yields a single marker beat (hit=0, last=1).
// Handshake: a transfer happens on a rising edge where valid and ready are both 1;
// the producer holds valid and payload stable until that edge.
module mask_decode
    import mask_pkg::*;
#(
    parameter int SEQ_WIDTH    = SEQ_WIDTH_DEF,
    parameter int OFFSET_WIDTH = OFFSET_WIDTH_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_valid,
    output logic                    i_ready,
    input  logic [SEQ_WIDTH-1:0]    i_mask,
    input  logic [OFFSET_WIDTH-1:0] i_base,
    output logic                    o_valid,
    input  logic                    o_ready,
    output logic [OFFSET_WIDTH-1:0] o_offset,
    output logic                    o_hit,
    output logic                    o_last
);

    localparam int IW = idx_width(SEQ_WIDTH);

    state_e                  state_q, state_d;
    logic [SEQ_WIDTH-1:0]    rem_mask_q, rem_mask_d;
    logic [OFFSET_WIDTH-1:0] base_q, base_d;

    logic [IW-1:0]           idx;
    logic                    any;
    logic                    single;
    logic                    scan;

    lsb_find #(
        .WIDTH (SEQ_WIDTH)
    ) u_lsb_find (
        .vec    (rem_mask_q),
        .idx    (idx),
        .any    (any),
        .single (single)
    );

    // Outputs come only from registers; they read as zero outside SCAN.
    assign scan     = (state_q == SCAN);
    assign i_ready  = !scan;
    assign o_valid  = scan;
    assign o_hit    = scan && any;
    assign o_last   = scan && single;
    assign o_offset = scan ? (base_q + OFFSET_WIDTH'(idx)) : '0;

    // Next-state: accept a window in IDLE, retire one hit per accepted beat in SCAN.
    always_comb begin
        state_d    = state_q;
        rem_mask_d = rem_mask_q;
        base_d     = base_q;
        case (state_q)
            IDLE: begin
                if (i_valid) begin
                    rem_mask_d = i_mask;
                    base_d     = i_base;
                    state_d    = SCAN;
                end
            end
            SCAN: begin
                if (o_ready) begin
                    rem_mask_d = rem_mask_q & ~(SEQ_WIDTH'(1) << idx);
                    if (single) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and window registers; reset drops any window in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rem_mask_q <= '0;
            base_q     <= '0;
        end else begin
            state_q    <= state_d;
            rem_mask_q <= rem_mask_d;
            base_q     <= base_d;
        end
    end

endmodule

// File: tb/tb_mask_decode.sv
// Directed testbench for mask_decode.
module tb_mask_decode;

    logic        clk;
    logic        rst_n;
    logic        i_valid;
    logic        i_ready;
    logic [19:0] i_mask;
    logic [6:0]  i_base;
    logic        o_valid;
    logic        o_ready;
    logic [6:0]  o_offset;
    logic        o_hit;
    logic        o_last;

    int checks;
    int failures;

    logic [6:0] got_off  [64];
    logic       got_hit  [64];
    logic       got_last [64];

    mask_decode #(
        .SEQ_WIDTH    (20),
        .OFFSET_WIDTH (7)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_valid  (i_valid),
        .i_ready  (i_ready),
        .i_mask   (i_mask),
        .i_base   (i_base),
        .o_valid  (o_valid),
        .o_ready  (o_ready),
        .o_offset (o_offset),
        .o_hit    (o_hit),
        .o_last   (o_last)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Driver: wait for i_ready (bounded), present one window for one cycle.
    task automatic send_window(input logic [19:0] m, input logic [6:0] b);
        int w;
        w = 0;
        @(negedge clk);
        while (!i_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (i_ready !== 1'b1) begin
            failures++;
            $display("FAIL send_ready: i_ready=%b required 1 within 50 cycles", i_ready);
        end
        i_mask  = m;
        i_base  = b;
        i_valid = 1'b1;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
    endtask

    // Records beats until the one flagged last is accepted (bounded); n = beats seen.
    task automatic collect_beats(output int n);
        n = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (o_valid === 1'b1) begin
                if (n < 64) begin
                    got_off[n]  = o_offset;
                    got_hit[n]  = o_hit;
                    got_last[n] = o_last;
                end
                n++;
                if (o_last === 1'b1 && o_ready === 1'b1) begin
                    @(posedge clk);
                    #1;
                    break;
                end
            end
        end
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        i_valid = 1'b0;
        i_mask  = '0;
        i_base  = '0;
        o_ready = 1'b1;
        repeat (3) @(negedge clk);
        checks += 5;
        if (i_ready !== 1'b1) begin failures++; $display("FAIL reset_i_ready: got %b want 1", i_ready); end
        if (o_valid !== 1'b0) begin failures++; $display("FAIL reset_o_valid: got %b want 0", o_valid); end
        if (o_offset !== 7'd0) begin failures++; $display("FAIL reset_o_offset: got %0d want 0", o_offset); end
        if (o_hit !== 1'b0) begin failures++; $display("FAIL reset_o_hit: got %b want 0", o_hit); end
        if (o_last !== 1'b0) begin failures++; $display("FAIL reset_o_last: got %b want 0", o_last); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int n;
        o_ready = 1'b1;
        send_window(20'h00005, 7'd0);
        collect_beats(n);
        checks++;
        if (n !== 2) begin failures++; $display("FAIL basic_count: got %0d want 2", n); end
        if (n >= 2) begin
            checks += 6;
            if (got_off[0] !== 7'd0) begin failures++; $display("FAIL basic_off0: got %0d want 0", got_off[0]); end
            if (got_hit[0] !== 1'b1) begin failures++; $display("FAIL basic_hit0: got %b want 1", got_hit[0]); end
            if (got_last[0] !== 1'b0) begin failures++; $display("FAIL basic_last0: got %b want 0", got_last[0]); end
            if (got_off[1] !== 7'd2) begin failures++; $display("FAIL basic_off1: got %0d want 2", got_off[1]); end
            if (got_hit[1] !== 1'b1) begin failures++; $display("FAIL basic_hit1: got %b want 1", got_hit[1]); end
            if (got_last[1] !== 1'b1) begin failures++; $display("FAIL basic_last1: got %b want 1", got_last[1]); end
        end
        @(negedge clk);
        checks += 2;
        if (i_ready !== 1'b1) begin failures++; $display("FAIL basic_ready_after: got %b want 1", i_ready); end
        if (o_valid !== 1'b0) begin failures++; $display("FAIL basic_valid_after: got %b want 0", o_valid); end
    endtask

    task automatic test_empty();
        int n;
        o_ready = 1'b1;
        send_window(20'h00000, 7'd10);
        collect_beats(n);
        checks++;
        if (n !== 1) begin failures++; $display("FAIL empty_count: got %0d want 1", n); end
        if (n >= 1) begin
            checks += 3;
            if (got_off[0] !== 7'd10) begin failures++; $display("FAIL empty_off: got %0d want 10", got_off[0]); end
            if (got_hit[0] !== 1'b0) begin failures++; $display("FAIL empty_hit: got %b want 0", got_hit[0]); end
            if (got_last[0] !== 1'b1) begin failures++; $display("FAIL empty_last: got %b want 1", got_last[0]); end
        end
    endtask

    task automatic test_wrap();
        int n;
        logic [6:0] exp_off;
        o_ready = 1'b1;
        send_window(20'hFFFFF, 7'd120);
        collect_beats(n);
        checks++;
        if (n !== 20) begin failures++; $display("FAIL wrap_count: got %0d want 20", n); end
        if (n >= 20) begin
            for (int i = 0; i < 20; i++) begin
                exp_off = 7'((120 + i) % 128);
                checks += 3;
                if (got_off[i] !== exp_off) begin failures++; $display("FAIL wrap_off[%0d]: got %0d want %0d", i, got_off[i], exp_off); end
                if (got_hit[i] !== 1'b1) begin failures++; $display("FAIL wrap_hit[%0d]: got %b want 1", i, got_hit[i]); end
                if (got_last[i] !== (i == 19)) begin failures++; $display("FAIL wrap_last[%0d]: got %b want %b", i, got_last[i], (i == 19)); end
            end
        end
    endtask

    task automatic test_stall();
        int n;
        o_ready = 1'b0;
        send_window(20'h80001, 7'd5);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks += 4;
            if (o_valid !== 1'b1) begin failures++; $display("FAIL stall_valid[%0d]: got %b want 1", k, o_valid); end
            if (o_offset !== 7'd5) begin failures++; $display("FAIL stall_off[%0d]: got %0d want 5", k, o_offset); end
            if (o_hit !== 1'b1) begin failures++; $display("FAIL stall_hit[%0d]: got %b want 1", k, o_hit); end
            if (o_last !== 1'b0) begin failures++; $display("FAIL stall_last[%0d]: got %b want 0", k, o_last); end
            if (k == 0) begin
                i_mask = 20'hFFFFF;
                i_base = 7'd99;
            end
            if (k == 3) o_ready = 1'b1;
        end
        collect_beats(n);
        checks++;
        if (n !== 1) begin failures++; $display("FAIL stall_tail_count: got %0d want 1", n); end
        if (n >= 1) begin
            checks += 3;
            if (got_off[0] !== 7'd24) begin failures++; $display("FAIL stall_tail_off: got %0d want 24", got_off[0]); end
            if (got_hit[0] !== 1'b1) begin failures++; $display("FAIL stall_tail_hit: got %b want 1", got_hit[0]); end
            if (got_last[0] !== 1'b1) begin failures++; $display("FAIL stall_tail_last: got %b want 1", got_last[0]); end
        end
    endtask

    task automatic test_reset_mid();
        int n;
        o_ready = 1'b1;
        send_window(20'h000F0, 7'd0);
        @(negedge clk);
        checks += 2;
        if (o_valid !== 1'b1) begin failures++; $display("FAIL mid_first_valid: got %b want 1", o_valid); end
        if (o_offset !== 7'd4) begin failures++; $display("FAIL mid_first_off: got %0d want 4", o_offset); end
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks += 2;
        if (o_valid !== 1'b0) begin failures++; $display("FAIL mid_async_valid: got %b want 0", o_valid); end
        if (i_ready !== 1'b1) begin failures++; $display("FAIL mid_async_ready: got %b want 1", i_ready); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (o_valid !== 1'b0) begin failures++; $display("FAIL mid_post_valid[%0d]: got %b want 0", k, o_valid); end
        end
        send_window(20'h00002, 7'd3);
        collect_beats(n);
        checks++;
        if (n !== 1) begin failures++; $display("FAIL mid_new_count: got %0d want 1", n); end
        if (n >= 1) begin
            checks += 3;
            if (got_off[0] !== 7'd4) begin failures++; $display("FAIL mid_new_off: got %0d want 4", got_off[0]); end
            if (got_hit[0] !== 1'b1) begin failures++; $display("FAIL mid_new_hit: got %b want 1", got_hit[0]); end
            if (got_last[0] !== 1'b1) begin failures++; $display("FAIL mid_new_last: got %b want 1", got_last[0]); end
        end
    endtask

    task automatic test_sweep();
        int n;
        logic [6:0] b;
        o_ready = 1'b1;
        for (int k = 0; k < 128; k++) begin
            b = 7'(k);
            send_window(20'h00001, b);
            collect_beats(n);
            checks++;
            if (n !== 1) begin failures++; $display("FAIL sweep_count[%0d]: got %0d want 1", k, n); end
            if (n >= 1) begin
                checks += 3;
                if (got_off[0] !== b) begin failures++; $display("FAIL sweep_off[%0d]: got %0d want %0d", k, got_off[0], b); end
                if (got_hit[0] !== 1'b1) begin failures++; $display("FAIL sweep_hit[%0d]: got %b want 1", k, got_hit[0]); end
                if (got_last[0] !== 1'b1) begin failures++; $display("FAIL sweep_last[%0d]: got %b want 1", k, got_last[0]); end
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_basic();
        test_empty();
        test_wrap();
        test_stall();
        test_reset_mid();
        test_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
